// File: rtl/fp_mant_mult_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_mant_mult_seq: iterative shift-add {hidden,mantissa} significand product |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fp_mant_mult_seq #(
  parameter int MANT_W     = 23,
  parameter int RADIX_BITS = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [MANT_W-1:0]         mant_a,
  input  logic [MANT_W-1:0]         mant_b,
  input  logic                      hidden_a,
  input  logic                      hidden_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*(MANT_W+1)-1:0]   product,
  output logic                      busy
);

  localparam int OP_W   = MANT_W + 1;
  localparam int PROD_W = 2 * OP_W;
  localparam int N      = OP_W / RADIX_BITS;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state_q, state_d;
  logic [OP_W-1:0]          a_q, a_d;
  logic [PROD_W-1:0]        acc_q, acc_d;
  logic [PROD_W-1:0]        prod_q, prod_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;

  logic                     w_last;
  logic [OP_W+RADIX_BITS-1:0] w_pp;
  logic [OP_W+RADIX_BITS-1:0] w_sum;
  logic [PROD_W-1:0]        w_acc_step;

  // acc holds {partial product high half, unconsumed multiplier bits}; the
  // multiplier drains out of the low end as the product fills in from the top.
  assign w_last = (cnt_q == LAST_CNT);
  assign w_pp   = {{RADIX_BITS{1'b0}}, a_q} * {{OP_W{1'b0}}, acc_q[RADIX_BITS-1:0]};
  assign w_sum  = {{RADIX_BITS{1'b0}}, acc_q[PROD_W-1:OP_W]} + w_pp;

  generate
    if (RADIX_BITS < OP_W) begin : g_shift
      assign w_acc_step = {w_sum, acc_q[OP_W-1:RADIX_BITS]};
    end else begin : g_single
      assign w_acc_step = w_sum;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid)  state_d = ST_BUSY;
      ST_BUSY: if (w_last)    state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
  end

  always_comb begin
    a_d    = a_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    prod_d = prod_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d   = {hidden_a, mant_a};
          acc_d = {{OP_W{1'b0}}, hidden_b, mant_b};
          cnt_d = '0;
        end
      end
      ST_BUSY: begin
        acc_d = w_acc_step;
        if (w_last) begin
          cnt_d  = '0;
          prod_d = w_acc_step;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      acc_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
    end else begin
      a_q    <= a_d;
      acc_q  <= acc_d;
      prod_q <= prod_d;
      cnt_q  <= cnt_d;
    end
  end

  assign product = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_mant_mult_seq.sv
`default_nettype none
// Scoreboard bench for fp_mant_mult_seq: random and directed operand pairs
// checked against a plain integer multiply of the full significands.
module tb_fp_mant_mult_seq #(
  parameter int RADIX_BITS = 1
);

  localparam int MANT_W = 23;
  localparam int N      = (MANT_W + 1) / RADIX_BITS;
  localparam int TMO    = 500;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [22:0] mant_a;
  logic [22:0] mant_b;
  logic        hidden_a;
  logic        hidden_b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        busy;

  fp_mant_mult_seq #(.MANT_W(MANT_W), .RADIX_BITS(RADIX_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mant_a    (mant_a),
    .mant_b    (mant_b),
    .hidden_a  (hidden_a),
    .hidden_b  (hidden_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [47:0] exp_q[$];
  int          acc_cyc_q[$];
  logic        prev_ov = 1'b0;

  function automatic logic [47:0] ref_mul(input logic ha, input logic [22:0] a,
                                          input logic hb, input logic [22:0] b);
    longint unsigned x, y, p;
    x = longint'(a) + (ha ? 64'd8388608 : 64'd0);
    y = longint'(b) + (hb ? 64'd8388608 : 64'd0);
    p = x * y;
    return p[47:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    $display("FAIL %s: timed out after %0d cycles (cycle %0d)", nm, TMO, cyc);
  endtask

  // Monitor: records accepts into the scoreboard and checks every DONE cycle.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      acc_cyc_q.delete();
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: got product 0x%0h expected no output (cycle %0d)", product, cyc);
        end else begin
          if (!prev_ov) chk("latency", 64'(cyc - acc_cyc_q[0]), 64'(N));
          chk("product", {16'd0, product}, {16'd0, exp_q[0]});
          chk("in_ready_done", {63'd0, in_ready}, 64'd0);
          chk("busy_done", {63'd0, busy}, 64'd1);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(acc_cyc_q.pop_front());
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_mul(hidden_a, mant_a, hidden_b, mant_b));
        acc_cyc_q.push_back(cyc + 1);
      end
      prev_ov = out_valid;
    end
  end

  task automatic send(input logic ha, input logic [22:0] a, input logic hb, input logic [22:0] b);
    int k = 0;
    hidden_a = ha; mant_a = a; hidden_b = hb; mant_b = b; in_valid = 1'b1;
    while (!in_ready && k < TMO) begin @(posedge clk); #1; k++; end
    if (k >= TMO) timeout("send");
    @(posedge clk); #1;
    in_valid = 1'b0;
    mant_a = 23'($urandom);
    mant_b = 23'($urandom);
    hidden_a = 1'($urandom);
  endtask

  task automatic wait_out();
    int k = 0;
    while (!out_valid && k < TMO) begin @(posedge clk); #1; k++; end
    if (k >= TMO) timeout("wait_out");
  endtask

  task automatic run_op(input logic ha, input logic [22:0] a, input logic hb,
                        input logic [22:0] b, input int stall);
    out_ready = (stall == 0);
    send(ha, a, hb, b);
    wait_out();
    repeat (stall) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int t[3];
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mant_a = '0; mant_b = '0; hidden_a = 1'b0; hidden_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_product",   {16'd0, product},   64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed corner operands
    run_op(1'b1, 23'h000000, 1'b1, 23'h000000, 0);
    run_op(1'b1, 23'h400000, 1'b1, 23'h400000, 0);
    run_op(1'b1, 23'h7FFFFF, 1'b1, 23'h7FFFFF, 0);
    run_op(1'b0, 23'h000000, 1'b1, 23'($urandom), 0);
    run_op(1'b1, 23'($urandom), 1'b0, 23'h000000, 2);
    chk("hold_after_handshake", {16'd0, product}, 64'd0);

    // backpressure with ignored input pulses
    out_ready = 1'b0;
    send(1'b1, 23'($urandom), 1'b1, 23'($urandom));
    wait_out();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; hidden_b = 1'($urandom);
      mant_a = 23'($urandom); mant_b = 23'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  {63'd0, in_ready},  64'd1);
    chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);

    // reset in the middle of an operation
    send(1'b1, 23'($urandom), 1'b1, 23'($urandom));
    repeat (10) begin @(posedge clk); #1; end
    if (N > 11) chk("midop_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midop_in_ready",  {63'd0, in_ready},  64'd1);
    chk("midop_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midop_busy_clr",  {63'd0, busy},      64'd0);
    chk("midop_product",   {16'd0, product},   64'd0);
    repeat (N + 4) begin @(posedge clk); #1; end
    run_op(1'b1, 23'($urandom), 1'b1, 23'($urandom), 0);

    // random operands with random backpressure
    for (int i = 0; i < 12; i++)
      run_op(($urandom_range(0, 7) != 0), 23'($urandom),
             ($urandom_range(0, 7) != 0), 23'($urandom), $urandom_range(0, 3));

    // back-to-back: in_valid and out_ready held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      hidden_a = 1'b1; hidden_b = 1'b1;
      mant_a = 23'($urandom); mant_b = 23'($urandom);
      k = 0;
      while (!in_ready && k < TMO) begin @(posedge clk); #1; k++; end
      if (k >= TMO) timeout("b2b_accept");
      @(posedge clk); #1;
      t[i] = cyc;
    end
    in_valid = 1'b0;
    chk("b2b_spacing0", 64'(t[1] - t[0]), 64'(N + 2));
    chk("b2b_spacing1", 64'(t[2] - t[1]), 64'(N + 2));

    repeat (2 * N + 10) begin @(posedge clk); #1; end
    chk("queue_drain", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
